// File: rtl/memguard_dispatcher.sv
// memguard_dispatcher: pops the MemGuard-selected FWFT queue and forwards one transaction at a time.
// Optional per-queue saturating served counters are built when DISPATCH_STATS_EN is defined.
module memguard_dispatcher #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int COUNTER_SIZE     = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   sched_valid,
    input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]    sched_selection,
    input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0] q_data,
    input  logic [NUMBER_OF_QUEUES-1:0]            q_empty,
    output logic [NUMBER_OF_QUEUES-1:0]            q_pop,
    output logic                                   update,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]    m_qid
`ifdef DISPATCH_STATS_EN
    ,
    output logic [NUMBER_OF_QUEUES*COUNTER_SIZE-1:0] served_count
`endif
);
    localparam int QW = $clog2(NUMBER_OF_QUEUES);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [QW-1:0]         cur_q_q, cur_q_d;
    logic [QW-1:0]         m_qid_q, m_qid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  update_q, update_d;
    logic [DATA_WIDTH-1:0] q_word [NUMBER_OF_QUEUES];
    logic                  sel_ok, head_ok, handshake;

    for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_word
        assign q_word[g] = q_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sel_ok    = sched_valid && (32'(sched_selection) < NUMBER_OF_QUEUES) && !q_empty[sched_selection];
    // The head is re-checked in GRANT; an emptied queue aborts the grant without a pop.
    assign head_ok   = (state_q == GRANT) && !q_empty[cur_q_q];
    assign handshake = m_valid && m_ready;

    always_comb begin
        state_d  = state_q;
        cur_q_d  = cur_q_q;
        m_data_d = m_data_q;
        m_qid_d  = m_qid_q;
        case (state_q)
            IDLE: begin
                if (sel_ok) begin
                    state_d = GRANT;
                    cur_q_d = sched_selection;
                end
            end
            GRANT: begin
                state_d = head_ok ? SEND : IDLE;
                if (head_ok) begin
                    m_data_d = q_word[cur_q_q];
                    m_qid_d  = cur_q_q;
                end
            end
            SEND: begin
                if (m_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        update_d = (state_d == GRANT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q_q  <= '0;
            m_data_q <= '0;
            m_qid_q  <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q_q  <= cur_q_d;
            m_data_q <= m_data_d;
            m_qid_q  <= m_qid_d;
            update_q <= update_d;
        end
    end

    assign update  = update_q;
    assign m_valid = (state_q == SEND);
    assign m_data  = m_data_q;
    assign m_qid   = m_qid_q;
    assign q_pop   = head_ok ? (NUMBER_OF_QUEUES'(1) << cur_q_q) : '0;

`ifdef DISPATCH_STATS_EN
    logic [COUNTER_SIZE-1:0] cnt_q [NUMBER_OF_QUEUES];
    logic [COUNTER_SIZE-1:0] cnt_d [NUMBER_OF_QUEUES];

    always_comb begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (handshake && m_qid_q == QW'(i) && cnt_q[i] != '1)
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_cnt
        assign served_count[g*COUNTER_SIZE +: COUNTER_SIZE] = cnt_q[g];
    end
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_memguard_dispatcher.sv
// tb_memguard_dispatcher: directed scenarios plus randomized traffic against a per-queue FIFO/scoreboard model.
module tb_memguard_dispatcher;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CS = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sched_valid = 1'b0;
    logic [1:0]    sched_selection = '0;
    logic [N*DW-1:0] q_data = '0;
    logic [N-1:0]  q_empty = '1;
    logic [N-1:0]  q_pop;
    logic          update;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [1:0]    m_qid;
`ifdef DISPATCH_STATS_EN
    logic [N*CS-1:0] served_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [63:0] fifo  [N][$];
    logic [63:0] exp_q [N][$];
    int served [N];

    always #5 clock = ~clock;

    memguard_dispatcher #(.NUMBER_OF_QUEUES(N), .DATA_WIDTH(DW), .COUNTER_SIZE(CS)) dut (
        .clock(clock), .reset(reset), .sched_valid(sched_valid), .sched_selection(sched_selection),
        .q_data(q_data), .q_empty(q_empty), .q_pop(q_pop), .update(update),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_qid(m_qid)
`ifdef DISPATCH_STATS_EN
        , .served_count(served_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_q();
        for (int i = 0; i < N; i++) begin
            q_empty[i] = (fifo[i].size() == 0);
            q_data[i*DW +: DW] = (fifo[i].size() > 0) ? fifo[i][0] : 64'hFFFF_FFFF_FFFF_FFFF;
        end
    endtask

    task automatic fill(input int q, input int n);
        logic [63:0] w;
        for (int k = 0; k < n; k++) begin
            w = {$urandom, $urandom};
            w[63] = 1'b0;
            fifo[q].push_back(w);
            exp_q[q].push_back(w);
        end
    endtask

    function automatic logic [63:0] sat(input int v);
        return (v > 15) ? 64'd15 : 64'(v);
    endfunction

    // Runs traffic until every queued word has been delivered or the cycle budget expires.
    task automatic run_model(input int max_cyc, input bit rnd);
        int cyc = 0;
        int left = 0;
        int pops = 0;
        int upds = 0;
        logic [N-1:0] p;
        logic hs, prev_stall;
        logic [63:0] d, prev_d, want;
        logic [1:0] id;
        prev_stall = 1'b0;
        prev_d = '0;
        for (int i = 0; i < N; i++) left += exp_q[i].size();
        while (left > 0 && cyc < max_cyc) begin
            sched_valid     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            sched_selection = rnd ? 2'($urandom_range(0, 3)) : 2'd0;
            m_ready         = rnd ? ($urandom_range(0, 4) > 1) : 1'b1;
            drive_q();
            #1;
            p = q_pop; hs = m_valid && m_ready; d = m_data; id = m_qid;
            chk("pop_onehot", 64'($countones(p) <= 1), 64'd1);
            if (prev_stall) chk("stall_stable", d, prev_d);
            if (hs) begin
                want = (exp_q[id].size() > 0) ? exp_q[id][0] : 64'hFFFF_FFFF_FFFF_FFFF;
                chk("data_order", d, want);
            end
            if (p != 0) pops++;
            if (update) upds++;
            prev_stall = m_valid && !m_ready;
            prev_d = d;
            step();
            for (int i = 0; i < N; i++)
                if (p[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
            if (hs && exp_q[id].size() > 0) begin
                void'(exp_q[id].pop_front());
                left--;
                served[id]++;
            end
            cyc++;
        end
        chk("drained", 64'(left), 64'd0);
        chk("update_per_pop", 64'(upds), 64'(pops));
        sched_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            served[i] = 0;
            fifo[i].delete();
            exp_q[i].delete();
        end
        drive_q();
        @(negedge clock);
        reset = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) served[i] = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_update", 64'(update), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_q_pop", 64'(q_pop), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_qid", 64'(m_qid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        step();

        // single transfer
        q_empty = 4'b1011; q_data[2*DW +: DW] = 64'hA5;
        sched_selection = 2'd2; sched_valid = 1'b1; m_ready = 1'b1;
        step();
        chk("t1_update", 64'(update), 64'd1);
        chk("t1_pop", 64'(q_pop), 64'b0100);
        chk("t1_mvalid_grant", 64'(m_valid), 64'd0);
        sched_valid = 1'b0;
        step();
        q_empty = 4'b1111;
        chk("t1_mvalid", 64'(m_valid), 64'd1);
        chk("t1_data", m_data, 64'hA5);
        chk("t1_qid", 64'(m_qid), 64'd2);
        chk("t1_update_send", 64'(update), 64'd0);
        step();
        chk("t1_idle", 64'(m_valid), 64'd0);

        // backpressure, with a competing request that must not be granted
        q_empty = 4'b1110; q_data[0 +: DW] = 64'h0123_4567_89AB_CDEF;
        sched_selection = 2'd0; sched_valid = 1'b1; m_ready = 1'b0;
        step();
        chk("t2_update", 64'(update), 64'd1);
        step();
        q_empty = 4'b1101; q_data[1*DW +: DW] = 64'h1111; sched_selection = 2'd1;
        for (int k = 0; k < 10; k++) begin
            chk("t2_mvalid", 64'(m_valid), 64'd1);
            chk("t2_data", m_data, 64'h0123_4567_89AB_CDEF);
            chk("t2_nopop", 64'(q_pop), 64'd0);
            chk("t2_noupd", 64'(update), 64'd0);
            step();
        end
        m_ready = 1'b1;
        chk("t2_mvalid_c11", 64'(m_valid), 64'd1);
        step();
        chk("t2_idle", 64'(m_valid), 64'd0);
        chk("t2_idle_upd", 64'(update), 64'd0);

        // selection changes 1 -> 3 during GRANT
        step();
        sched_selection = 2'd3; q_data[3*DW +: DW] = 64'h3333; q_empty = 4'b0101;
        #1;
        chk("t3_update", 64'(update), 64'd1);
        chk("t3_pop", 64'(q_pop), 64'b0010);
        sched_valid = 1'b0;
        step();
        q_empty = 4'b0111;
        chk("t3_qid", 64'(m_qid), 64'd1);
        chk("t3_data", m_data, 64'h1111);
        step();

        // abort: selected queue empties before GRANT
        sched_valid = 1'b1;
        step();
        q_empty = 4'b1111; sched_valid = 1'b0;
        #1;
        chk("t4_update", 64'(update), 64'd1);
        chk("t4_nopop", 64'(q_pop), 64'd0);
        step();
        chk("t4_update_fall", 64'(update), 64'd0);
        chk("t4_nomvalid", 64'(m_valid), 64'd0);
        step();
        chk("t4_nomvalid2", 64'(m_valid), 64'd0);

        // asynchronous reset while in SEND
        q_empty = 4'b1110; q_data[0 +: DW] = 64'h0BAD;
        sched_selection = 2'd0; sched_valid = 1'b1; m_ready = 1'b0;
        step();
        sched_valid = 1'b0;
        step();
        q_empty = 4'b1111;
        chk("t5_send", 64'(m_valid), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("t5_async_mvalid", 64'(m_valid), 64'd0);
        chk("t5_async_update", 64'(update), 64'd0);
        chk("t5_async_data", m_data, 64'd0);
        #2;
        reset = 1'b0;
        step();
        chk("t5_after_mvalid", 64'(m_valid), 64'd0);
        chk("t5_after_update", 64'(update), 64'd0);

        // randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < N; i++) fill(i, $urandom_range(0, 6));
        fill(2, 1);
        run_model(3000, 1'b1);
`ifdef DISPATCH_STATS_EN
        for (int i = 0; i < N; i++)
            chk("rand_served", 64'(served_count[i*CS +: CS]), sat(served[i]));
`endif

        // 20 transfers from queue 0 saturate its counter
        do_reset();
`ifdef DISPATCH_STATS_EN
        chk("stats_cleared", 64'(served_count), 64'd0);
`endif
        fill(0, 20);
        run_model(200, 1'b0);
        chk("sat_transfers", 64'(served[0]), 64'd20);
`ifdef DISPATCH_STATS_EN
        for (int i = 0; i < N; i++)
            chk("sat_served", 64'(served_count[i*CS +: CS]), (i == 0) ? 64'd15 : 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
